regfile_write_sequencer: RTL

// - Owns the single write port (writeEnable/writeAddress3/writeData) of the 32x32 register file.
// - After reset, sweeps x1..x(N_REGS-1) to zero, because the register array has no reset of its own.
// - Then arbitrates two write requesters onto the port:
//   - A = core writeback, priority.
//   - B = secondary source (load return / debug).
// - Uses valid/ready handshakes; write-port outputs are registered.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_write_sequencer.sv | 110 +++++++++++
 2 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port sequencer.
package regfile_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int N_REGS = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } regfile_seq_state_t;

endpackage

// File: rtl/regfile_write_sequencer.sv
// Owns the register-file write port: zero-sweeps x1..x(N_REGS-1) after reset,
// then arbitrates writeback (A, priority) and a secondary source (B, anti-starvation).
module regfile_write_sequencer #(
  parameter int ADDR_W         = regfile_pkg::ADDR_W,
  parameter int DATA_W         = regfile_pkg::DATA_W,
  parameter int N_REGS         = regfile_pkg::N_REGS,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_aValid,
  output logic              o_aReady,
  input  logic [ADDR_W-1:0] i_aAddr,
  input  logic [DATA_W-1:0] i_aData,
  input  logic              i_bValid,
  output logic              o_bReady,
  input  logic [ADDR_W-1:0] i_bAddr,
  input  logic [DATA_W-1:0] i_bData,
  output logic              o_writeEnable,
  output logic [ADDR_W-1:0] o_writeAddress3,
  output logic [DATA_W-1:0] o_writeData,
  output logic              o_busy
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(N_REGS - 1);
  localparam regfile_pkg::regfile_seq_state_t RESET_STATE =
    CLEAR_ON_RESET ? regfile_pkg::CLEAR : regfile_pkg::RUN;

  regfile_pkg::regfile_seq_state_t state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [WAIT_W-1:0] wait_q;
  logic              busy_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic force_b;
  logic a_ready;
  logic b_ready;

  // B jumps ahead of A only once it has waited STARVE_LIMIT consecutive cycles.
  always_comb begin
    force_b = (wait_q >= WAIT_MAX);
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (state_q == regfile_pkg::RUN) begin
      a_ready = i_aValid & ~(force_b & i_bValid);
      b_ready = i_bValid & (~i_aValid | force_b);
    end
  end

  assign o_aReady        = a_ready;
  assign o_bReady        = b_ready;
  assign o_writeEnable   = we_q;
  assign o_writeAddress3 = addr_q;
  assign o_writeData     = data_q;
  assign o_busy          = busy_q;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= RESET_STATE;
      ptr_q   <= ADDR_W'(1);
      busy_q  <= CLEAR_ON_RESET;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        regfile_pkg::CLEAR: begin
          we_q   <= 1'b1;
          addr_q <= ptr_q;
          data_q <= '0;
          ptr_q  <= ptr_q + ADDR_W'(1);
          if (ptr_q == LAST_REG) begin
            state_q <= regfile_pkg::RUN;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          // Accepted writes to x0 are swallowed: no strobe, port address/data held.
          if (a_ready && (i_aAddr != '0)) begin
            we_q   <= 1'b1;
            addr_q <= i_aAddr;
            data_q <= i_aData;
          end else if (b_ready && (i_bAddr != '0)) begin
            we_q   <= 1'b1;
            addr_q <= i_bAddr;
            data_q <= i_bData;
          end else begin
            we_q <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wait_q <= '0;
    end else if (i_bValid && !b_ready) begin
      if (wait_q < WAIT_MAX) wait_q <= wait_q + WAIT_W'(1);
    end else begin
      wait_q <= '0;
    end
  end

endmodule
